// File: rtl/uc_dsp_pkg.sv
// rtl/uc_dsp_pkg.sv - shared constants and helpers for the upconversion DSP chain
package uc_dsp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [63:0] unity_gain(input int gfrac);
    return 64'd1 << gfrac;
  endfunction

  function automatic logic [63:0] dac_mid(input int ow);
    return 64'd1 << (ow - 1);
  endfunction

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/mixer_adder_tree.sv
// rtl/mixer_adder_tree.sv - registered pairwise adder tree with valid pipeline
module mixer_adder_tree
  import uc_dsp_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 16,
  parameter int SW  = DW + clog2(NCH)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH*DW-1:0]    in_data,
  output logic signed [SW-1:0] sum,
  output logic                 sum_valid
);

  localparam int LV = clog2(NCH);

  function automatic int lvl_cnt(input int l);
    return (NCH + (1 << l) - 1) >> l;
  endfunction

  function automatic int clampi(input int i);
    return (i < NCH) ? i : NCH - 1;
  endfunction

  logic signed [SW-1:0] ext [NCH];

  always_comb begin
    for (int k = 0; k < NCH; k++) ext[k] = SW'($signed(in_data[k*DW +: DW]));
  end

  if (LV == 0) begin : g_flat
    assign sum       = ext[0];
    assign sum_valid = in_valid;
  end else begin : g_tree
    for (genvar l = 0; l < LV; l++) begin : lv
      logic signed [SW-1:0] d [NCH];
      logic signed [SW-1:0] q [NCH];
      logic                 dv;
      logic                 v;

      if (l == 0) begin : g_first
        always_comb begin
          for (int k = 0; k < NCH; k++) d[k] = ext[k];
        end
        assign dv = in_valid;
      end else begin : g_next
        always_comb begin
          for (int k = 0; k < NCH; k++) d[k] = lv[l-1].q[k];
        end
        assign dv = lv[l-1].v;
      end

      // An odd leftover operand is carried through this level unchanged.
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          for (int k = 0; k < NCH; k++) q[k] <= '0;
        end else begin
          v <= dv;
          for (int j = 0; j < NCH; j++) begin
            if (j < lvl_cnt(l + 1)) begin
              if (2 * j + 1 < lvl_cnt(l)) q[j] <= d[clampi(2 * j)] + d[clampi(2 * j + 1)];
              else                        q[j] <= d[clampi(2 * j)];
            end else begin
              q[j] <= '0;
            end
          end
        end
      end
    end

    assign sum       = lv[LV-1].q[0];
    assign sum_valid = lv[LV-1].v;
  end

endmodule

// File: rtl/dac_channel_mixer.sv
// rtl/dac_channel_mixer.sv - N-channel gain, saturate and sum stage feeding the DAC
module dac_channel_mixer
  import uc_dsp_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int GW    = 32,
  parameter int GFRAC = 30,
  parameter int OW    = 14,
  parameter int CNTW  = 16
) (
  input  logic                                   sys_clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [NCH*DW-1:0]                      ch_data,
  input  logic [NCH-1:0]                         ch_enable,
  input  logic                                   gain_wr_en,
  input  logic [((clog2(NCH) > 0) ? clog2(NCH) : 1)-1:0] gain_wr_idx,
  input  logic [GW-1:0]                          gain_wr_data,
  input  logic                                   gain_commit,
  input  logic                                   sync_in,
  output logic                                   commit_pending,
  output logic [OW-1:0]                          dac_data,
  output logic                                   dac_valid,
  output logic [NCH-1:0]                         ovf_sticky,
  output logic [CNTW-1:0]                        ovf_count,
  input  logic                                   ovf_clear
);

  localparam int LV = clog2(NCH);
  localparam int SW = DW + LV;
  localparam int PW = DW + GW + 1;

  logic [GW-1:0] shadow_q [NCH];
  logic [GW-1:0] shadow_d [NCH];
  logic [GW-1:0] active_q [NCH];
  logic          apply;

  always_comb begin
    for (int k = 0; k < NCH; k++) shadow_d[k] = shadow_q[k];
    if (gain_wr_en && (int'(gain_wr_idx) < NCH)) shadow_d[gain_wr_idx] = gain_wr_data;
  end

  // A write landing in the apply cycle is part of the committed set.
  assign apply = (commit_pending | gain_commit) & sync_in;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= GW'(unity_gain(GFRAC));
        active_q[k] <= GW'(unity_gain(GFRAC));
      end
    end else begin
      commit_pending <= apply ? 1'b0 : (commit_pending | gain_commit);
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= shadow_d[k];
        if (apply) active_q[k] <= shadow_d[k];
      end
    end
  end

  logic signed [PW-1:0] prod_d [NCH];
  logic signed [PW-1:0] prod_q [NCH];
  logic                 s1_valid;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      logic signed [DW-1:0] samp;
      samp      = ch_enable[k] ? $signed(ch_data[k*DW +: DW]) : '0;
      prod_d[k] = PW'(samp) * $signed({1'b0, active_q[k]});
    end
  end

  logic [NCH*DW-1:0] s2_d;
  logic [NCH*DW-1:0] s2_q;
  logic [NCH-1:0]    sat_d;
  logic              s2_valid;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      logic signed [PW-1:0] shifted;
      logic signed [63:0]   wide;
      logic signed [63:0]   clamped;
      shifted            = prod_q[k] >>> GFRAC;
      wide               = 64'(shifted);
      clamped            = saturate(wide, DW);
      s2_d[k*DW +: DW]   = clamped[DW-1:0];
      sat_d[k]           = s1_valid && (clamped != wide);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_q     <= '0;
      for (int k = 0; k < NCH; k++) prod_q[k] <= '0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s2_q     <= s2_d;
      for (int k = 0; k < NCH; k++) prod_q[k] <= prod_d[k];
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= '0;
      ovf_count  <= '0;
    end else if (ovf_clear) begin
      ovf_sticky <= '0;
      ovf_count  <= '0;
    end else begin
      ovf_sticky <= ovf_sticky | sat_d;
      if ((|sat_d) && (ovf_count != {CNTW{1'b1}})) ovf_count <= ovf_count + 1'b1;
    end
  end

  logic signed [SW-1:0] tree_sum;
  logic                 tree_valid;

  mixer_adder_tree #(
    .NCH (NCH),
    .DW  (DW),
    .SW  (SW)
  ) u_tree (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_valid  (s2_valid),
    .in_data   (s2_q),
    .sum       (tree_sum),
    .sum_valid (tree_valid)
  );

  // Inverting the MSB of the truncated sum yields offset binary.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dac_data  <= OW'(dac_mid(OW));
      dac_valid <= 1'b0;
    end else begin
      dac_data  <= {~tree_sum[SW-1], tree_sum[SW-2 -: OW-1]};
      dac_valid <= tree_valid;
    end
  end

endmodule

// File: tb/tb_dac_channel_mixer.sv
// tb/tb_dac_channel_mixer.sv - directed self-checking bench for dac_channel_mixer
module tb_dac_channel_mixer;

  localparam int NCH = 2, DW = 16, GW = 32, GFRAC = 30, OW = 14, CNTW = 16;

  logic              sys_clk;
  logic              rst;
  logic              in_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_enable;
  logic              gain_wr_en;
  logic [0:0]        gain_wr_idx;
  logic [GW-1:0]     gain_wr_data;
  logic              gain_commit;
  logic              sync_in;
  logic              commit_pending;
  logic [OW-1:0]     dac_data;
  logic              dac_valid;
  logic [NCH-1:0]    ovf_sticky;
  logic [CNTW-1:0]   ovf_count;
  logic              ovf_clear;

  int checks = 0;
  int errors = 0;

  dac_channel_mixer #(
    .NCH(NCH), .DW(DW), .GW(GW), .GFRAC(GFRAC), .OW(OW), .CNTW(CNTW)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .ch_data        (ch_data),
    .ch_enable      (ch_enable),
    .gain_wr_en     (gain_wr_en),
    .gain_wr_idx    (gain_wr_idx),
    .gain_wr_data   (gain_wr_data),
    .gain_commit    (gain_commit),
    .sync_in        (sync_in),
    .commit_pending (commit_pending),
    .dac_data       (dac_data),
    .dac_valid      (dac_valid),
    .ovf_sticky     (ovf_sticky),
    .ovf_count      (ovf_count),
    .ovf_clear      (ovf_clear)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c0, input int c1);
    ch_data = {c1[15:0], c0[15:0]};
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ch_data = '0; ch_enable = 2'b11;
    gain_wr_en = 1'b0; gain_wr_idx = '0; gain_wr_data = '0;
    gain_commit = 1'b0; sync_in = 1'b0; ovf_clear = 1'b0;
    step(3);
    chk("rst_dac_data", 32'(dac_data), 32'h2000);
    chk("rst_dac_valid", 32'(dac_valid), 0);
    chk("rst_pending", 32'(commit_pending), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    chk("rst_ovf_sticky", 32'(ovf_sticky), 0);
    rst = 1'b0;
    step(1);

    in_valid = 1'b1;
    step(3);
    chk("lat_valid_low", 32'(dac_valid), 0);
    step(1);
    chk("lat_valid_high", 32'(dac_valid), 1);
    chk("zero_midscale", 32'(dac_data), 32'h2000);

    set_ch(1000, -200);
    step(4);
    chk("unity_sum", 32'(dac_data), 8292);

    ch_enable = 2'b01;
    step(4);
    chk("enable_mask", 32'(dac_data), 8317);
    ch_enable = 2'b11;
    step(4);
    chk("enable_restore", 32'(dac_data), 8292);

    gain_wr_en = 1'b1; gain_wr_idx = 1'b0; gain_wr_data = 32'h8000_0000;
    step(1);
    gain_wr_en = 1'b0;
    step(4);
    chk("shadow_only", 32'(dac_data), 8292);
    chk("no_pending", 32'(commit_pending), 0);

    gain_commit = 1'b1;
    step(1);
    gain_commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pending_hold", 32'(commit_pending), 1);
      chk("pending_out", 32'(dac_data), 8292);
      step(1);
    end
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    chk("pending_clear", 32'(commit_pending), 0);
    step(3);
    chk("apply_old_gain", 32'(dac_data), 8292);
    step(1);
    chk("apply_new_gain", 32'(dac_data), 8417);

    set_ch(30000, -200);
    step(2);
    chk("sat_sticky", 32'(ovf_sticky), 32'b01);
    chk("sat_count1", 32'(ovf_count), 1);
    step(2);
    chk("sat_count3", 32'(ovf_count), 3);
    chk("sat_output", 32'(dac_data), 12262);
    ovf_clear = 1'b1;
    step(1);
    chk("clear_count", 32'(ovf_count), 0);
    chk("clear_sticky", 32'(ovf_sticky), 0);
    ovf_clear = 1'b0;
    step(1);
    chk("after_clear_count", 32'(ovf_count), 1);
    chk("after_clear_sticky", 32'(ovf_sticky), 32'b01);

    set_ch(1000, -200);
    gain_wr_en = 1'b1; gain_wr_idx = 1'b1; gain_wr_data = 32'h8000_0000;
    gain_commit = 1'b1;
    step(1);
    gain_wr_en = 1'b0; gain_commit = 1'b0;
    chk("mid_pending", 32'(commit_pending), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(dac_data), 32'h2000);
    chk("mid_rst_valid", 32'(dac_valid), 0);
    chk("mid_rst_pending", 32'(commit_pending), 0);
    chk("mid_rst_count", 32'(ovf_count), 0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 0);
    step(1);
    rst = 1'b0;
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    chk("restart_pending", 32'(commit_pending), 0);
    step(2);
    chk("restart_valid_low", 32'(dac_valid), 0);
    step(1);
    chk("restart_valid", 32'(dac_valid), 1);
    chk("restart_unity", 32'(dac_data), 8292);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
